// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Issue controller sitting between the instruction decode unit (idu) and the
// execute unit (exu).
//   * Keeps one busy bit per GPR for every register write that has been issued
//     but not yet completed.
//   * Holds back a decoded instruction on a RAW or WAW hazard, and limits the
//     number of issued-but-uncompleted instructions to MAX_INFLIGHT.
//   * On ebreak or an invalid instruction, stops issuing, waits for all
//     in-flight work to complete, then parks the core in a halted state.
//
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//   defined   : a register cleared by this cycle's completion already counts as
//               not busy in the hazard check, so a dependent instruction can
//               issue in the same cycle as the completion.
//   undefined : the hazard check uses the registered busy vector only, so a
//               dependent instruction issues at the earliest one cycle after
//               its producer completes.
//
// Handshake (decode side and issue side share one decision):
//   An instruction moves from idu to exu in a cycle where dec_valid_i and
//   dec_ready_o are both high. This is a zero-cycle pass-through with no
//   buffering: iss_valid_o is dec_valid_i qualified by the scoreboard's
//   can-issue decision, and dec_ready_o is that same decision qualified by
//   iss_ready_i. Neither ready depends on the opposite valid, so no
//   combinational loop forms through this block.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   dec_valid_i        decoded instruction valid
//   dec_ready_o        scoreboard accepts the instruction this cycle
//   dec_rs1_i/_use_    source 1 index / source 1 is read
//   dec_rs2_i/_use_    source 2 index / source 2 is read
//   dec_rd_i/_use_     destination index / destination is written
//   dec_halt_i         instruction is ebreak or invalid
//   dec_invld_i        qualifies dec_halt_i: 1 = invalid, 0 = ebreak
//   iss_valid_o        issue to exu
//   iss_ready_i        exu accepts
//   cmp_valid_i        one instruction completed
//   cmp_wen_i          the completion writes a GPR
//   cmp_rd_i           completion destination
//   busy_o             busy vector (debug)
//   inflight_o         number of issued-but-uncompleted instructions
//   halted_o           core halted
//   halt_cause_o       0 = ebreak, 1 = invalid instruction
//   proto_err_o        sticky protocol error
//   state_o            controller state (debug): 0 = RUN, 1 = DRAIN, 2 = HALT
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int MAX_INFLIGHT   = 4,
  parameter int CNT_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_valid_i,
  output logic                      dec_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic                      dec_use_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic                      dec_use_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd_i,
  input  logic                      dec_use_rd_i,
  input  logic                      dec_halt_i,
  input  logic                      dec_invld_i,
  output logic                      iss_valid_o,
  input  logic                      iss_ready_i,
  input  logic                      cmp_valid_i,
  input  logic                      cmp_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] cmp_rd_i,
  output logic [NUM_REGS-1:0]       busy_o,
  output logic [CNT_WIDTH-1:0]      inflight_o,
  output logic                      halted_o,
  output logic                      halt_cause_o,
  output logic                      proto_err_o,
  output logic [1:0]                state_o
);

  localparam logic [CNT_WIDTH-1:0]      LP_MAX  = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0]      LP_ONE  = CNT_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] LP_X0   = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [NUM_REGS-1:0]  r_busy;
  logic [CNT_WIDTH-1:0] r_inflight;
  logic                 r_halt_cause;
  logic                 r_proto_err;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t               w_state_nxt;
  logic                 w_halt_cause_nxt;
  logic [NUM_REGS-1:0]  w_clr_mask;
  logic [NUM_REGS-1:0]  w_set_mask;
  logic [NUM_REGS-1:0]  w_busy_eff;
  logic [NUM_REGS-1:0]  w_busy_nxt;
  logic [CNT_WIDTH-1:0] w_inflight_nxt;
  logic                 w_proto_err_nxt;
  logic                 w_cmp_clr;
  logic                 w_cmp_dec;
  logic                 w_hz_rs1;
  logic                 w_hz_rs2;
  logic                 w_hz_rd;
  logic                 w_hz;
  logic                 w_room;
  logic                 w_can_issue;
  logic                 w_fire;
  logic                 w_halt_req;
  logic                 w_err_empty;
  logic                 w_err_halted;
  logic                 w_err_not_busy;

  // A completion only touches the busy vector when it writes a real GPR.
  assign w_cmp_clr = cmp_valid_i & cmp_wen_i & (cmp_rd_i != LP_X0);

  always_comb begin
    w_clr_mask = '0;
    if (w_cmp_clr) begin
      w_clr_mask[cmp_rd_i] = 1'b1;
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The completing register is already free as far as the hazard check goes.
  assign w_busy_eff = r_busy & ~w_clr_mask;
`else
  assign w_busy_eff = r_busy;
`endif

  // ---------------------------------------------------------------------------
  // Hazard detection. x0 never carries a dependency.
  // ---------------------------------------------------------------------------
  assign w_hz_rs1 = dec_use_rs1_i & (dec_rs1_i != LP_X0) & w_busy_eff[dec_rs1_i];
  assign w_hz_rs2 = dec_use_rs2_i & (dec_rs2_i != LP_X0) & w_busy_eff[dec_rs2_i];
  assign w_hz_rd  = dec_use_rd_i  & (dec_rd_i  != LP_X0) & w_busy_eff[dec_rd_i];
  assign w_hz     = w_hz_rs1 | w_hz_rs2 | w_hz_rd;

  // A full window still admits a new instruction when one retires this cycle,
  // keeping the count at MAX_INFLIGHT.
  assign w_room = (r_inflight < LP_MAX) | cmp_valid_i;

  // A halting instruction is never issued; it only steers the controller.
  assign w_can_issue = (r_state == ST_RUN) & ~dec_halt_i & ~w_hz & w_room;

  assign iss_valid_o = dec_valid_i & w_can_issue;
  assign dec_ready_o = w_can_issue & iss_ready_i;
  assign w_fire      = dec_valid_i & dec_ready_o;

  // The halt request beats any hazard on the same instruction.
  assign w_halt_req  = (r_state == ST_RUN) & dec_valid_i & dec_halt_i;

  // ---------------------------------------------------------------------------
  // Busy vector update: clear from completion, then set from issue, so the set
  // wins when both hit the same register.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_set_mask = '0;
    if (w_fire && dec_use_rd_i && (dec_rd_i != LP_X0)) begin
      w_set_mask[dec_rd_i] = 1'b1;
    end
  end

  assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

  // ---------------------------------------------------------------------------
  // In-flight counter. A completion with nothing outstanding is ignored by the
  // counter (and flagged below) so the count never wraps.
  // ---------------------------------------------------------------------------
  assign w_cmp_dec = cmp_valid_i & (r_inflight != '0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    unique case ({w_fire, w_cmp_dec})
      2'b10:   w_inflight_nxt = r_inflight + LP_ONE;
      2'b01:   w_inflight_nxt = r_inflight - LP_ONE;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Protocol errors (sticky until reset).
  // Clearing a register that is not busy also covers the set-and-clear
  // collision on one register when no bypass is present: the hazard check only
  // lets that write issue if the register was already idle. With the bypass, a
  // completion freeing a register that a new write immediately reclaims is
  // legal and only the set is kept.
  // ---------------------------------------------------------------------------
  assign w_err_empty    = cmp_valid_i & (r_inflight == '0);
  assign w_err_halted   = cmp_valid_i & (r_state == ST_HALT);
  assign w_err_not_busy = w_cmp_clr & ~r_busy[cmp_rd_i];

  assign w_proto_err_nxt = r_proto_err | w_err_empty | w_err_halted | w_err_not_busy;

  // ---------------------------------------------------------------------------
  // Controller FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_halt_cause_nxt = r_halt_cause;
    unique case (r_state)
      ST_RUN: begin
        if (w_halt_req) begin
          w_state_nxt      = ST_DRAIN;
          w_halt_cause_nxt = dec_invld_i;
        end
      end
      ST_DRAIN: begin
        // Uses the registered count: the halt is entered one cycle after the
        // last completion has been absorbed.
        if (r_inflight == '0) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_busy       <= '0;
      r_inflight   <= '0;
      r_halt_cause <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= w_busy_nxt;
      r_inflight   <= w_inflight_nxt;
      r_halt_cause <= w_halt_cause_nxt;
      r_proto_err  <= w_proto_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o       = r_busy;
  assign inflight_o   = r_inflight;
  assign halted_o     = (r_state == ST_HALT);
  assign halt_cause_o = r_halt_cause;
  assign proto_err_o  = r_proto_err;
  assign state_o      = r_state;

endmodule
